j_acc_collector: RTL and testbench

Serial-to-parallel receiver that sits at the far end of the j_acc_shifter serial link (serial_output/serial_start/serial_en).
- Captures a stream of 32-bit words sent LSB-first and writes each completed word into a single-port SRAM.
- Writes go to consecutive addresses starting at start_addr.
- Used to land accumulator/activation images from the serial datapath back into SRAM, one job of img_size+1 words per collect_start.

---
 rtl/j_acc_collector.sv | 107 ++++++++++
 tb/tb_j_acc_collector.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/j_acc_collector.sv
// Serial-to-parallel receiver for the j_acc_shifter link: assembles LSB-first words and
// writes each completed word to consecutive SRAM addresses from a latched start address.
module j_acc_collector #(
  parameter int unsigned SRAM_DEPTH = 1024,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned ADDR_W = $clog2(SRAM_DEPTH),
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data_o,
  input  logic                  collect_start,
  output logic                  collect_idle,
  input  logic                  collect_ctrl,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W-1:0]     img_size,
  input  logic                  serial_input,
  input  logic                  serial_start,
  input  logic                  serial_en
);

  typedef enum logic [1:0] {StIdle, StRecv, StDone} state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [ADDR_W-1:0]      word_cnt_q;
  logic [ADDR_W-1:0]      base_q;
  logic [ADDR_W-1:0]      last_q;
  logic                   drop_q;
  logic [DATA_WIDTH-1:0]  shift_q;
  logic [DATA_WIDTH-1:0]  word_next;
  logic                   word_done;

  // serial_start restarts assembly at bit 0, discarding any partial word.
  always_comb begin
    word_next = shift_q;
    if (serial_start) begin
      word_next    = '0;
      word_next[0] = serial_input;
    end else begin
      word_next[bit_cnt_q] = serial_input;
    end
  end

  assign word_done = serial_en && !serial_start && (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign sram_we   = sram_en;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      base_q       <= '0;
      last_q       <= '0;
      drop_q       <= 1'b0;
      shift_q      <= '0;
      sram_en      <= 1'b0;
      sram_addr    <= '0;
      sram_data_o  <= '0;
      collect_idle <= 1'b1;
    end else begin
      sram_en <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (collect_start) begin
            state_q      <= StRecv;
            base_q       <= start_addr;
            last_q       <= img_size;
            drop_q       <= collect_ctrl;
            word_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            collect_idle <= 1'b0;
          end
        end
        StRecv: begin
          if (serial_en) begin
            shift_q <= word_next;
            if (word_done) begin
              bit_cnt_q  <= '0;
              word_cnt_q <= word_cnt_q + 1'b1;
              // Write pulse lands in the cycle after the last bit; address wraps naturally.
              if (!drop_q) begin
                sram_en     <= 1'b1;
                sram_addr   <= base_q + word_cnt_q;
                sram_data_o <= word_next;
              end
              if (word_cnt_q == last_q) begin
                state_q <= StDone;
              end
            end else begin
              bit_cnt_q <= serial_start ? CNT_W'(1) : bit_cnt_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_q      <= StIdle;
          collect_idle <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_j_acc_collector.sv
// Randomized scoreboard bench for j_acc_collector: expected writes are queued as words are
// sent; a negedge monitor pops and compares every observed SRAM write.
module tb_j_acc_collector;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sram_en, sram_we, collect_idle;
  logic [9:0]  sram_addr;
  logic [31:0] sram_data_o;
  logic        collect_start, collect_ctrl;
  logic [9:0]  start_addr, img_size;
  logic        serial_input, serial_start, serial_en;

  j_acc_collector dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sram_en       (sram_en),
    .sram_we       (sram_we),
    .sram_addr     (sram_addr),
    .sram_data_o   (sram_data_o),
    .collect_start (collect_start),
    .collect_idle  (collect_idle),
    .collect_ctrl  (collect_ctrl),
    .start_addr    (start_addr),
    .img_size      (img_size),
    .serial_input  (serial_input),
    .serial_start  (serial_start),
    .serial_en     (serial_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] words[$];
  logic [31:0] tb_ram[DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wr_count = 0;
  int          last_wr_cyc = 0;
  bit          have_last = 0;
  bit          gap_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write pulse must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (sram_en) begin
      wr_t e;
      wr_count++;
      check("we_eq_en", 64'(sram_we), 64'(1));
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h", sram_addr, sram_data_o);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 64'(sram_addr), 64'(e.addr));
        check("wr_data", 64'(sram_data_o), 64'(e.data));
      end
      tb_ram[sram_addr] = sram_data_o;
      if (gap_chk && have_last) check("wr_gap", 64'(cyc - last_wr_cyc), 64'(32));
      last_wr_cyc = cyc;
      have_last   = 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit bub, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      while (bub && $urandom_range(1) == 1) begin
        serial_en    = 1'b0;
        serial_start = 1'($urandom_range(1));
        serial_input = 1'($urandom_range(1));
        tick();
      end
      serial_en    = 1'b1;
      serial_start = (b == 0);
      serial_input = w[b];
      tick();
      serial_en    = 1'b0;
      serial_start = 1'b0;
    end
  endtask

  task automatic start_job(input bit drop, input int sa, input int sz);
    collect_start = 1'b1;
    collect_ctrl  = drop;
    start_addr    = 10'(sa);
    img_size      = 10'(sz);
    tick();
    collect_start = 1'b0;
    // Scramble config inputs so only latched values can be used.
    start_addr    = 10'($urandom);
    img_size      = 10'($urandom);
    collect_ctrl  = 1'($urandom_range(1));
    check("idle_low_after_start", 64'(collect_idle), 64'(0));
  endtask

  task automatic expect_word(input bit drop, input int sa, input int i, input logic [31:0] w);
    wr_t e;
    if (!drop) begin
      e.addr = 10'((sa + i) % DEPTH);
      e.data = w;
      sb.push_back(e);
    end
  endtask

  // Called right after the final bit has been sampled.
  task automatic end_job(input bit drop, input int w0, input int nwords);
    check("idle_low_in_last_pulse", 64'(collect_idle), 64'(0));
    check("last_pulse_en", 64'(sram_en), 64'(!drop));
    tick();
    check("idle_after_last_pulse", 64'(collect_idle), 64'(1));
    check("en_low_after_job", 64'(sram_en), 64'(0));
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    check("write_count", 64'(wr_count - w0), 64'(drop ? 0 : nwords));
  endtask

  task automatic run_job(input bit drop, input int sa, input int sz, input bit bub);
    int w0 = wr_count;
    start_job(drop, sa, sz);
    for (int i = 0; i <= sz; i++) begin
      if (bub && i == 5) begin
        // A start pulse while busy must not disturb the running job.
        collect_start = 1'b1;
        tick();
        collect_start = 1'b0;
      end
      expect_word(drop, sa, i, words[i]);
      send_word(words[i], bub, 32);
    end
    end_job(drop, w0, sz + 1);
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  initial begin
    int w0;
    reset_n       = 1'b0;
    collect_start = 1'b0;
    collect_ctrl  = 1'b0;
    start_addr    = '0;
    img_size      = '0;
    serial_input  = 1'b0;
    serial_start  = 1'b0;
    serial_en     = 1'b0;
    tick();
    tick();
    check("rst_en", 64'(sram_en), 64'(0));
    check("rst_we", 64'(sram_we), 64'(0));
    check("rst_addr", 64'(sram_addr), 64'(0));
    check("rst_data", 64'(sram_data_o), 64'(0));
    check("rst_idle", 64'(collect_idle), 64'(1));
    reset_n = 1'b1;
    tick();

    // Back-to-back store job with fixed 32-cycle write spacing.
    words.delete();
    for (int i = 0; i < 10; i++) words.push_back(32'(i));
    gap_chk   = 1;
    have_last = 0;
    run_job(0, 0, 9, 0);
    gap_chk = 0;
    check("ram9", 64'(tb_ram[9]), 64'(9));

    // Same job with bubbles and a busy start pulse.
    run_job(0, 0, 9, 1);

    // Address wrap.
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back(32'hA5A5_0000 + 32'(i));
    run_job(0, 1020, 7, 1);
    check("ram1023", 64'(tb_ram[1023]), 64'h A5A5_0003);
    check("ram0", 64'(tb_ram[0]), 64'h A5A5_0004);

    // Drop job then a normal store job.
    rand_words(10);
    run_job(1, 500, 9, 1);
    rand_words(4);
    run_job(0, 300, 3, 0);

    // Single-word job.
    rand_words(1);
    run_job(0, 1023, 0, 1);

    // Resync mid-word 2.
    rand_words(5);
    w0 = wr_count;
    start_job(0, 40, 4);
    for (int i = 0; i < 2; i++) begin
      expect_word(0, 40, i, words[i]);
      send_word(words[i], 1, 32);
    end
    send_word($urandom, 1, 13);
    expect_word(0, 40, 2, 32'hDEAD_BEEF);
    send_word(32'hDEAD_BEEF, 1, 32);
    for (int i = 3; i < 5; i++) begin
      expect_word(0, 40, i, words[i]);
      send_word(words[i], 1, 32);
    end
    end_job(0, w0, 5);

    // Reset in the middle of word 4.
    rand_words(10);
    w0 = wr_count;
    start_job(0, 50, 9);
    for (int i = 0; i < 4; i++) begin
      expect_word(0, 50, i, words[i]);
      send_word(words[i], 0, 32);
    end
    send_word(words[4], 0, 10);
    reset_n = 1'b0;
    tick();
    check("midrst_en", 64'(sram_en), 64'(0));
    check("midrst_addr", 64'(sram_addr), 64'(0));
    check("midrst_data", 64'(sram_data_o), 64'(0));
    check("midrst_idle", 64'(collect_idle), 64'(1));
    reset_n = 1'b1;
    send_word($urandom, 0, 32);
    send_word($urandom, 1, 32);
    check("midrst_writes", 64'(wr_count - w0), 64'(4));
    check("midrst_sb", 64'(sb.size()), 64'(0));
    rand_words(2);
    run_job(0, 200, 1, 0);

    // Random jobs.
    for (int j = 0; j < 4; j++) begin
      int sz = $urandom_range(5);
      rand_words(sz + 1);
      run_job(1'($urandom_range(1)), $urandom_range(DEPTH - 1), sz, 1);
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
